// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32 front end: widths, reset defaults, the fetch
// FSM state type and the {pc, instr} entry carried through the prefetch buffer.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        RUN
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. The head word is presented combinationally
// and reads as zero whenever the FIFO is empty.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & ~flush & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of the order the statements are written in.
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked by
    // count/pointers and an empty FIFO never exposes the array contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    overflow_a: assert property (@(posedge clk) disable iff (rst)
        (push && !flush && full) |-> pop);

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 fetch stage: owns the PC, issues word requests over req/gnt/rvalid and
// hands buffered {instr, pc} pairs to decode through a valid/ready handshake.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [ILEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [CW:0]     in_use;

    logic            issue;
    logic            flush;
    logic            resp;
    logic            resp_keep;
    logic            pop;

    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic [CW-1:0]   buf_count;
    logic            buf_full;
    logic            buf_empty;

    logic [XLEN-1:0] tag_pc;
    logic [CW-1:0]   tag_count;
    logic            tag_full;
    logic            tag_empty;

    // Words in flight plus words buffered may never exceed the buffer depth,
    // which is what makes a push into a full prefetch buffer impossible.
    assign in_use = {1'b0, outstanding} + {1'b0, buf_count};

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can
        // leave a value unassigned and infer a latch.
        state_next = state;
        imem_req_o = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_next = RUN;
            end
            RUN: begin
                if (!start_i) state_next = IDLE;
                imem_req_o = start_i & ~redirect_i & (in_use < (CW+1)'(FIFO_DEPTH));
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_addr_o = pc;
    assign issue       = imem_req_o & imem_gnt_i;
    // A redirect seen while idle only retargets the PC; nothing is flushed.
    assign flush       = redirect_i & (state == RUN);
    assign resp        = imem_rvalid_i & (outstanding != '0);
    assign resp_keep   = resp & (drop == '0) & ~flush;
    assign pop         = instr_valid_o & instr_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            pc          <= word_align(RESET_PC);
            outstanding <= '0;
            drop        <= '0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding + CW'(issue) - CW'(resp);
            if (flush) begin
                // Everything still in flight after this edge belongs to the old stream.
                drop <= outstanding - CW'(resp);
            end else if (resp && drop != '0) begin
                drop <= drop - CW'(1);
            end
            if (redirect_i) begin
                pc <= word_align(redirect_pc_i);
            end else if (issue) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

    // In-order tags: the address of each live request, popped as its word returns.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_tag_queue (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (flush),
        .push  (issue),
        .wdata (pc),
        .pop   (resp_keep),
        .rdata (tag_pc),
        .count (tag_count),
        .full  (tag_full),
        .empty (tag_empty)
    );

    assign push_entry = '{pc: tag_pc, instr: imem_rdata_i};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_prefetch (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (flush),
        .push  (resp_keep),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign instr_valid_o = ~buf_empty;
    assign instr_o       = head_entry.instr;
    assign instr_pc_o    = head_entry.pc;

    rvalid_expected_a: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> (outstanding != '0));
    tag_available_a: assert property (@(posedge clk_i) disable iff (rst_i)
        resp_keep |-> !tag_empty);
    tag_room_a: assert property (@(posedge clk_i) disable iff (rst_i)
        issue |-> !tag_full);
    tag_tracks_live_a: assert property (@(posedge clk_i) disable iff (rst_i)
        tag_count == outstanding - drop);
    full_blocks_req_a: assert property (@(posedge clk_i) disable iff (rst_i)
        buf_full |-> !imem_req_o);

endmodule
